// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: synchronizes the start/clear buttons and paces
// one-cycle increment/clear strobes to the external two-digit BCD counter.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned PRE_W       = 27,
  parameter int unsigned STOP_AT_MAX = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clr,
  input  logic [3:0] dig0_in,
  input  logic [3:0] dig1_in,
  output logic       d_inc,
  output logic       d_clr,
  output logic       wrap,
  output logic       running,
  output logic       max_flag
);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  localparam logic [PRE_W-1:0] TickMax = PRE_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             max_q, max_d;
  logic             inc_q, inc_d;
  logic             clr_q, clr_d;
  logic             wrap_q, wrap_d;
  logic [1:0]       start_sync_q, clr_sync_q;
  logic             start_prev_q, clr_prev_q;

  logic start_evt, clr_evt, tick, at_max;

  // Rising edge of the synchronized level; holding the button yields one event.
  assign start_evt = start_sync_q[1] & ~start_prev_q;
  assign clr_evt   = clr_sync_q[1] & ~clr_prev_q;
  assign tick      = (state_q == StRun) && (pre_q == TickMax);
  assign at_max    = (dig0_in == 4'd9) && (dig1_in == 4'd9);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    max_d   = max_q;
    inc_d   = 1'b0;
    clr_d   = 1'b0;
    wrap_d  = 1'b0;
    if (clr_evt) begin
      // Clear outranks start and any pending tick in every state.
      clr_d   = 1'b1;
      pre_d   = '0;
      max_d   = 1'b0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          pre_d = '0;
          if (start_evt) state_d = StRun;
        end
        StRun: begin
          if (start_evt) begin
            state_d = StPause;
          end else if (tick) begin
            pre_d = '0;
            if ((STOP_AT_MAX != 0) && at_max) begin
              max_d   = 1'b1;
              state_d = StPause;
            end else begin
              inc_d  = 1'b1;
              wrap_d = at_max;
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        StPause: begin
          if (start_evt && !max_q) state_d = StRun;
        end
        default: begin
          state_d = StIdle;
          pre_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pre_q        <= '0;
      max_q        <= 1'b0;
      inc_q        <= 1'b0;
      clr_q        <= 1'b0;
      wrap_q       <= 1'b0;
      start_sync_q <= 2'b00;
      clr_sync_q   <= 2'b00;
      start_prev_q <= 1'b0;
      clr_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      max_q        <= max_d;
      inc_q        <= inc_d;
      clr_q        <= clr_d;
      wrap_q       <= wrap_d;
      start_sync_q <= {start_sync_q[0], btn_start};
      clr_sync_q   <= {clr_sync_q[0], btn_clr};
      start_prev_q <= start_sync_q[1];
      clr_prev_q   <= clr_sync_q[1];
    end
  end

  // Strobes are registered so no input port reaches an output combinationally.
  assign d_inc    = inc_q;
  assign d_clr    = clr_q;
  assign wrap     = wrap_q;
  assign running  = (state_q == StRun);
  assign max_flag = max_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: one wrapping instance with a BCD counter model,
// one halt-at-99 instance with digits tied to 9/9.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start, btn_clr;
  logic [3:0] c0, c1;
  logic       d_inc, d_clr, wrap, running, max_flag;
  logic       load;

  logic       m_start, m_clr;
  logic [3:0] m_d0, m_d1;
  logic       m_inc, m_dclr, m_wrap, m_running, m_max;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(4), .PRE_W(3), .STOP_AT_MAX(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_start(btn_start),
    .btn_clr  (btn_clr),
    .dig0_in  (c0),
    .dig1_in  (c1),
    .d_inc    (d_inc),
    .d_clr    (d_clr),
    .wrap     (wrap),
    .running  (running),
    .max_flag (max_flag)
  );

  stopwatch_ctrl #(.TICK_DIV(4), .PRE_W(3), .STOP_AT_MAX(1)) dut_m (
    .clk      (clk),
    .reset    (reset),
    .btn_start(m_start),
    .btn_clr  (m_clr),
    .dig0_in  (m_d0),
    .dig1_in  (m_d1),
    .d_inc    (m_inc),
    .d_clr    (m_dclr),
    .wrap     (m_wrap),
    .running  (m_running),
    .max_flag (m_max)
  );

  // External two-digit BCD counter driven by the wrapping instance.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      c0 <= 4'd0;
      c1 <= 4'd0;
    end else if (load) begin
      c0 <= 4'd9;
      c1 <= 4'd9;
    end else if (d_clr) begin
      c0 <= 4'd0;
      c1 <= 4'd0;
    end else if (d_inc) begin
      if (c0 == 4'd9) begin
        c0 <= 4'd0;
        c1 <= (c1 == 4'd9) ? 4'd0 : c1 + 4'd1;
      end else begin
        c0 <= c0 + 4'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advances until d_inc is seen (bounded); leaves time just after that edge.
  task automatic wait_inc(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (d_inc === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: d_inc never seen, got 0 want 1 within 10 cycles", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_start = ~btn_start;
      btn_clr   = (i % 3) == 0;
      m_start   = ~m_start;
      m_clr     = (i % 2) == 0;
      #3;
      total++;
      if ({d_inc, d_clr, wrap, running, max_flag, m_inc, m_dclr, m_wrap, m_running, m_max}
          !== 10'b0) begin
        bad++;
        $display("FAIL reset_outputs: got %b want 0", {d_inc, d_clr, wrap, running, max_flag,
                 m_inc, m_dclr, m_wrap, m_running, m_max});
      end
      step();
    end
    btn_start = 1'b0;
    btn_clr   = 1'b0;
    m_start   = 1'b0;
    m_clr     = 1'b0;
    reset     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({d_inc, d_clr, wrap, running, max_flag, m_running, m_max} !== 7'b0) begin
        bad++;
        $display("FAIL post_reset_idle: got %b want 0",
                 {d_inc, d_clr, wrap, running, max_flag, m_running, m_max});
      end
    end
  endtask

  task automatic test_idle_clear();
    int pulses = 0;
    btn_clr = 1'b1;
    step();
    step();
    total++;
    if (d_clr !== 1'b0) begin bad++; $display("FAIL idle_clr_early: got %b want 0", d_clr); end
    step();
    total++;
    if (d_clr !== 1'b1) begin bad++; $display("FAIL idle_clr_pulse: got %b want 1", d_clr); end
    for (int i = 0; i < 8; i++) begin
      step();
      if (d_clr === 1'b1) pulses++;
      if (i == 3) btn_clr = 1'b0;
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL idle_clr_hold: got %0d want 0", pulses); end
    total++;
    if (running !== 1'b0) begin bad++; $display("FAIL idle_stays: got %b want 0", running); end
  endtask

  task automatic test_start_run();
    btn_start = 1'b1;
    step();
    step();
    total++;
    if (running !== 1'b0) begin bad++; $display("FAIL start_early: got %b want 0", running); end
    step();
    total++;
    if (running !== 1'b1) begin bad++; $display("FAIL start_run: got %b want 1", running); end
    btn_start = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      step();
      total++;
      if ({d_inc, wrap, d_clr} !== {((k % 4) == 0), 2'b00}) begin
        bad++;
        $display("FAIL run_cadence k=%0d: got inc/wrap/clr %b want %b", k,
                 {d_inc, wrap, d_clr}, {((k % 4) == 0), 2'b00});
      end
    end
    step();
    total++;
    if ({c1, c0} !== 8'h20) begin bad++; $display("FAIL count_20: got %h want 20", {c1, c0}); end
  endtask

  task automatic test_pause_resume();
    int incs = 0;
    wait_inc("pause_sync");
    btn_start = 1'b1;
    step();
    step();
    total++;
    if (running !== 1'b1) begin bad++; $display("FAIL pause_early: got %b want 1", running); end
    step();
    total++;
    if (running !== 1'b0) begin bad++; $display("FAIL pause_enter: got %b want 0", running); end
    btn_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (d_inc === 1'b1 || running !== 1'b0) incs++;
    end
    total++;
    if (incs != 0) begin bad++; $display("FAIL pause_hold: got %0d want 0", incs); end
    btn_start = 1'b1;
    step();
    step();
    step();
    total++;
    if ({running, d_inc} !== 2'b10) begin
      bad++;
      $display("FAIL resume_enter: got %b want 10", {running, d_inc});
    end
    btn_start = 1'b0;
    step();
    total++;
    if (d_inc !== 1'b0) begin bad++; $display("FAIL resume_early: got %b want 0", d_inc); end
    step();
    total++;
    if (d_inc !== 1'b1) begin bad++; $display("FAIL resume_inc: got %b want 1", d_inc); end
  endtask

  task automatic test_wrap();
    wait_inc("wrap_sync");
    load = 1'b1;
    step();
    load = 1'b0;
    total++;
    if ({c1, c0} !== 8'h99) begin bad++; $display("FAIL wrap_load: got %h want 99", {c1, c0}); end
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({d_inc, wrap} !== 2'b00) begin
        bad++;
        $display("FAIL wrap_early: got %b want 00", {d_inc, wrap});
      end
    end
    step();
    total++;
    if ({d_inc, wrap} !== 2'b11) begin
      bad++;
      $display("FAIL wrap_pulse: got %b want 11", {d_inc, wrap});
    end
    step();
    total++;
    if ({c1, c0, d_inc, wrap} !== 10'b0) begin
      bad++;
      $display("FAIL wrap_after: got %h/%b want 00/00", {c1, c0}, {d_inc, wrap});
    end
  endtask

  task automatic test_collision();
    wait_inc("collide_sync");
    step();
    btn_start = 1'b1;
    btn_clr   = 1'b1;
    step();
    step();
    step();
    total++;
    if ({d_clr, d_inc, running} !== 3'b100) begin
      bad++;
      $display("FAIL collide: got clr/inc/run %b want 100", {d_clr, d_inc, running});
    end
    btn_start = 1'b0;
    btn_clr   = 1'b0;
    step();
    total++;
    if ({d_clr, d_inc, running, c1, c0} !== 11'b0) begin
      bad++;
      $display("FAIL collide_after: got %b want 0", {d_clr, d_inc, running, c1, c0});
    end
  endtask

  task automatic test_stop_at_max();
    int runs = 0;
    m_d0    = 4'd9;
    m_d1    = 4'd9;
    m_start = 1'b1;
    step();
    step();
    step();
    total++;
    if (m_running !== 1'b1) begin bad++; $display("FAIL max_run: got %b want 1", m_running); end
    m_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({m_running, m_inc} !== 2'b10) begin
        bad++;
        $display("FAIL max_pre: got %b want 10", {m_running, m_inc});
      end
    end
    step();
    total++;
    if ({m_inc, m_wrap, m_running, m_max} !== 4'b0001) begin
      bad++;
      $display("FAIL max_halt: got %b want 0001", {m_inc, m_wrap, m_running, m_max});
    end
    step();
    m_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (m_running !== 1'b0 || m_max !== 1'b1 || m_inc !== 1'b0) runs++;
      if (i == 4) m_start = 1'b0;
    end
    total++;
    if (runs != 0) begin bad++; $display("FAIL max_start_ignored: got %0d want 0", runs); end
    m_clr = 1'b1;
    step();
    step();
    step();
    total++;
    if ({m_dclr, m_max, m_running} !== 3'b100) begin
      bad++;
      $display("FAIL max_clear: got %b want 100", {m_dclr, m_max, m_running});
    end
    m_clr = 1'b0;
    step();
    total++;
    if ({m_dclr, m_max} !== 2'b00) begin
      bad++;
      $display("FAIL max_clear_after: got %b want 00", {m_dclr, m_max});
    end
  endtask

  task automatic test_reset_mid_run();
    int runs = 0;
    btn_start = 1'b1;
    step();
    step();
    step();
    btn_start = 1'b0;
    step();
    total++;
    if (running !== 1'b1) begin bad++; $display("FAIL mid_run_enter: got %b want 1", running); end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({running, d_inc, d_clr, wrap, max_flag} !== 5'b0) begin
      bad++;
      $display("FAIL async_reset: got %b want 0", {running, d_inc, d_clr, wrap, max_flag});
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (running !== 1'b0 || d_inc !== 1'b0) runs++;
    end
    total++;
    if (runs != 0) begin bad++; $display("FAIL post_async_idle: got %0d want 0", runs); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    btn_start = 1'b0;
    btn_clr   = 1'b0;
    m_start   = 1'b0;
    m_clr     = 1'b0;
    m_d0      = 4'd0;
    m_d1      = 4'd0;
    load      = 1'b0;
    test_reset();
    test_idle_clear();
    test_start_run();
    test_pause_resume();
    test_wrap();
    test_collision();
    test_stop_at_max();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
